// File: rtl/uart_stream_bridge.sv
// uart_stream_bridge: polls a memory-mapped UART over a single-cycle register bus,
// moving bytes between a one-byte TX holding register and a small RX FIFO.
module uart_stream_bridge #(
  parameter int POLL_GAP = 4,
  parameter int RXDEPTH  = 4
) (
  input  logic        CLK,
  input  logic        RESN,
  output logic        RD,
  output logic        WR,
  output logic [3:0]  BE,
  output logic [31:0] DATAO,
  input  logic [31:0] DATAI,
  input  logic        IRQ,
  input  logic        TX_VALID,
  input  logic [7:0]  TX_DATA,
  output logic        TX_READY,
  output logic        RX_VALID,
  output logic [7:0]  RX_DATA,
  input  logic        RX_READY
);
  localparam int AW = $clog2(RXDEPTH);
  localparam int CW = AW + 1;
  localparam logic [7:0] GAP_LOAD = 8'(POLL_GAP);

  typedef enum logic [1:0] {GAP, POLL, RXRD, TXWR} state_t;

  state_t          state, state_nx;
  logic [7:0]      gap_cnt, gap_nx;
  logic            hold_full;
  logic [7:0]      hold_byte;
  logic [7:0]      mem [RXDEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            fifo_full, push, pop;

  // Baud timer and unused status bits are deliberately ignored.
  logic unused_datai;
  assign unused_datai = ^{DATAI[31:16], DATAI[7:2]};

  assign fifo_full = (count == CW'(RXDEPTH));
  assign push      = (state == RXRD);
  assign pop       = RX_VALID && RX_READY;

  assign TX_READY  = !hold_full;
  assign RX_VALID  = (count != '0);
  assign RX_DATA   = RX_VALID ? mem[rd_ptr] : 8'h00;

  // Bus strobes decode straight from the state so reset clears them asynchronously.
  always_comb begin
    RD    = 1'b0;
    WR    = 1'b0;
    BE    = 4'b0000;
    DATAO = 32'h0;
    case (state)
      POLL: begin RD = 1'b1; BE = 4'b0001; end
      RXRD: begin RD = 1'b1; BE = 4'b0010; end
      TXWR: begin WR = 1'b1; BE = 4'b0010; DATAO = {16'h0, hold_byte, 8'h00}; end
      default: ;
    endcase
  end

  // Next state: RX drain has priority over TX so the UART receiver empties first.
  always_comb begin
    state_nx = state;
    gap_nx   = gap_cnt;
    case (state)
      GAP: begin
        if (gap_cnt == 8'd0 || IRQ) state_nx = POLL;
        else                        gap_nx   = gap_cnt - 8'd1;
      end
      POLL: begin
        if (DATAI[1] && !fifo_full)      state_nx = RXRD;
        else if (!DATAI[0] && hold_full) state_nx = TXWR;
        else begin
          state_nx = GAP;
          gap_nx   = GAP_LOAD;
        end
      end
      default: begin
        state_nx = GAP;
        gap_nx   = GAP_LOAD;
      end
    endcase
  end

  // FSM and gap counter registers.
  always_ff @(posedge CLK or negedge RESN) begin
    if (!RESN) begin
      state   <= GAP;
      gap_cnt <= GAP_LOAD;
    end else begin
      state   <= state_nx;
      gap_cnt <= gap_nx;
    end
  end

  // TX holding register: cleared by the write access, refilled only while empty.
  always_ff @(posedge CLK or negedge RESN) begin
    if (!RESN) begin
      hold_full <= 1'b0;
      hold_byte <= 8'h00;
    end else if (state == TXWR) begin
      hold_full <= 1'b0;
    end else if (TX_VALID && !hold_full) begin
      hold_full <= 1'b1;
      hold_byte <= TX_DATA;
    end
  end

  // RX FIFO pointers and occupancy; push and pop in the same cycle cancel in count.
  always_ff @(posedge CLK or negedge RESN) begin
    if (!RESN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // RX FIFO storage; contents are masked by RX_VALID so no reset is needed.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= DATAI[15:8];
  end
endmodule

// File: tb/tb_uart_stream_bridge.sv
// Bench for uart_stream_bridge: transaction-level model of the poll schedule,
// TX holding byte and RX FIFO, checked every cycle, plus directed literal pins.
module tb_uart_stream_bridge;
  localparam int PG    = 4;
  localparam int DEPTH = 4;
  localparam int OP_NONE = 0, OP_POLL = 1, OP_RXRD = 2, OP_TXWR = 3;

  logic        CLK = 1'b0;
  logic        RESN = 1'b0;
  logic        RD, WR, TX_READY, RX_VALID;
  logic [3:0]  BE;
  logic [31:0] DATAO;
  logic [31:0] DATAI = 32'h0;
  logic        IRQ = 1'b0, TX_VALID = 1'b0, RX_READY = 1'b0;
  logic [7:0]  TX_DATA = 8'h0, RX_DATA;

  uart_stream_bridge #(.POLL_GAP(PG), .RXDEPTH(DEPTH)) dut (
    .CLK(CLK), .RESN(RESN), .RD(RD), .WR(WR), .BE(BE), .DATAO(DATAO),
    .DATAI(DATAI), .IRQ(IRQ), .TX_VALID(TX_VALID), .TX_DATA(TX_DATA),
    .TX_READY(TX_READY), .RX_VALID(RX_VALID), .RX_DATA(RX_DATA), .RX_READY(RX_READY)
  );

  always #5 CLK = ~CLK;

  int tests = 0, fails = 0;

  // stimulus knobs
  logic       k_txv = 0, k_rxr = 0, k_irq = 0, k_busy = 0;
  logic [7:0] k_txd = 0;

  // model state
  logic [7:0] uart_q[$];
  logic [7:0] fifo_m[$];
  logic [7:0] hold_m[$];
  int         prev_op, cur_op, idle_run, cyc;
  logic       prev_irq;
  logic [7:0] poll_status;
  bit         poll_full, poll_hold;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  // Which bus access the rules demand in the current cycle.
  function automatic int expect_op();
    if (prev_op == OP_POLL) begin
      if (poll_status[1] && !poll_full)     return OP_RXRD;
      else if (!poll_status[0] && poll_hold) return OP_TXWR;
      else                                   return OP_NONE;
    end
    if (prev_op != OP_NONE) return OP_NONE;
    if (idle_run == PG + 1 || prev_irq) return OP_POLL;
    return OP_NONE;
  endfunction

  task automatic check_outputs();
    logic [3:0]  ebe;
    logic [31:0] edo;
    ebe = (cur_op == OP_POLL) ? 4'b0001 : (cur_op == OP_NONE) ? 4'b0000 : 4'b0010;
    edo = (cur_op == OP_TXWR) ? {16'h0, hold_m[0], 8'h00} : 32'h0;
    chk("rd", RD, (cur_op == OP_POLL || cur_op == OP_RXRD));
    chk("wr", WR, (cur_op == OP_TXWR));
    chk("rd_wr_excl", RD & WR, 0);
    chk("be", BE, ebe);
    chk("datao", DATAO, edo);
    chk("tx_ready", TX_READY, hold_m.size() == 0);
    chk("rx_valid", RX_VALID, fifo_m.size() != 0);
    if (fifo_m.size() != 0) chk("rx_data", RX_DATA, fifo_m[0]);
  endtask

  task automatic drive();
    logic [7:0] rb;
    rb = (uart_q.size() != 0) ? uart_q[0] : 8'h00;
    TX_VALID = k_txv;
    TX_DATA  = k_txd;
    RX_READY = k_rxr;
    IRQ      = k_irq;
    DATAI    = {16'($urandom), rb, 6'h0, uart_q.size() != 0, k_busy};
  endtask

  // Apply what the coming rising edge does to the abstract state.
  task automatic model_edge();
    if (cur_op == OP_POLL) begin
      poll_status = DATAI[7:0];
      poll_full   = (fifo_m.size() == DEPTH);
      poll_hold   = (hold_m.size() != 0);
    end
    if (cur_op == OP_RXRD) chk("push_not_full", fifo_m.size() < DEPTH, 1);
    if (fifo_m.size() != 0 && RX_READY) void'(fifo_m.pop_front());
    if (cur_op == OP_RXRD) begin
      fifo_m.push_back(DATAI[15:8]);
      void'(uart_q.pop_front());
    end
    if (cur_op == OP_TXWR) void'(hold_m.pop_front());
    else if (TX_VALID && hold_m.size() == 0) hold_m.push_back(TX_DATA);
    prev_op  = cur_op;
    idle_run = (cur_op == OP_NONE) ? idle_run + 1 : 0;
    prev_irq = IRQ;
  endtask

  task automatic step();
    drive();
    model_edge();
    @(negedge CLK);
    cyc++;
    cur_op = expect_op();
    check_outputs();
  endtask

  // Called at a negedge; asserts reset asynchronously mid-cycle, releases at a later negedge.
  task automatic do_reset();
    RESN = 1'b0;
    #1;
    chk("rst_rd", RD, 0);
    chk("rst_wr", WR, 0);
    chk("rst_be", BE, 0);
    chk("rst_datao", DATAO, 0);
    chk("rst_tx_ready", TX_READY, 1);
    chk("rst_rx_valid", RX_VALID, 0);
    chk("rst_rx_data", RX_DATA, 0);
    fifo_m.delete(); hold_m.delete(); uart_q.delete();
    k_txv = 0; k_rxr = 0; k_irq = 0; k_busy = 0;
    drive();
    repeat (2) @(negedge CLK);
    RESN = 1'b1;
    prev_op = OP_NONE; cur_op = OP_NONE; idle_run = 0; prev_irq = 0; cyc = 0;
    check_outputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int rdc[$];
    int polls, wr_busy, wr_tot, nrx;
    logic [7:0] wbytes[$];
    logic [7:0] got[$];
    bit seen;

    @(negedge CLK);
    do_reset();

    // Idle polling cadence
    for (int i = 0; i < 12; i++) begin
      step();
      if (RD) rdc.push_back(cyc);
    end
    chk("idle_rd_count", rdc.size(), 2);
    if (rdc.size() == 2) begin
      chk("idle_first_poll", rdc[0], 5);
      chk("idle_second_poll", rdc[1], 11);
    end

    // Single TX byte
    do_reset();
    k_txv = 1; k_txd = 8'h41;
    step();
    k_txv = 0;
    while (cyc < 6) step();
    chk("tx_wr", WR, 1);
    chk("tx_be", BE, 4'b0010);
    chk("tx_datao", DATAO, 32'h0000_4100);
    step();
    chk("tx_ready_back", TX_READY, 1);

    // TX blocked by busy UART for three polls
    do_reset();
    k_busy = 1; k_txv = 1; k_txd = 8'h77;
    step();
    k_txv = 0;
    polls = 0; wr_busy = 0; wr_tot = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (WR) begin
        wr_tot++;
        wbytes.push_back(DATAO[15:8]);
        if (k_busy) wr_busy++;
      end
      if (RD && BE == 4'b0001 && k_busy) begin
        polls++;
        if (polls == 3) k_busy = 0;
      end
    end
    chk("blocked_wr_while_busy", wr_busy, 0);
    chk("blocked_wr_total", wr_tot, 1);
    if (wbytes.size() == 1) chk("blocked_wr_byte", wbytes[0], 8'h77);

    // Single RX byte
    do_reset();
    uart_q.push_back(8'h5A);
    while (cyc < 6) step();
    chk("rx_rd", RD, 1);
    chk("rx_be", BE, 4'b0010);
    step();
    chk("rx_valid_lit", RX_VALID, 1);
    chk("rx_data_lit", RX_DATA, 8'h5A);

    // RX FIFO fill, stall, single pop, then drain in order
    do_reset();
    for (int b = 1; b <= 5; b++) uart_q.push_back(8'(b));
    nrx = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (RD && BE == 4'b0010) nrx++;
    end
    chk("full_rxrd_count", nrx, 4);
    chk("full_head", RX_DATA, 8'h01);
    k_rxr = 1;
    got.push_back(RX_DATA);
    step();
    k_rxr = 0;
    nrx = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (RD && BE == 4'b0010) nrx++;
    end
    chk("full_fifth_rxrd", nrx, 1);
    k_rxr = 1;
    for (int i = 0; i < 8; i++) begin
      if (RX_VALID) got.push_back(RX_DATA);
      step();
    end
    k_rxr = 0;
    chk("drain_count", got.size(), 5);
    for (int b = 0; b < 5; b++)
      if (b < got.size()) chk("drain_order", got[b], 8'(b + 1));

    // IRQ cuts the gap short
    do_reset();
    step(); step();
    k_irq = 1;
    step();
    k_irq = 0;
    chk("irq_poll_rd", RD, 1);
    chk("irq_poll_be", BE, 4'b0001);

    // Reset while the write access is on the bus, with a byte also buffered in RX
    do_reset();
    uart_q.push_back(8'h33);
    k_txv = 1; k_txd = 8'h99;
    step();
    k_txv = 0;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step();
      if (WR) seen = 1;
    end
    chk("txwr_reached", seen, 1);
    chk("txwr_rx_buffered", RX_VALID, 1);
    do_reset();
    for (int i = 0; i < 5; i++) step();

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      k_txv = 1'($urandom % 2);
      k_txd = 8'($urandom);
      k_rxr = ($urandom % 4) != 0;
      k_irq = ($urandom % 8) == 0;
      if ($urandom % 4 == 0) k_busy = 1'($urandom % 2);
      if (uart_q.size() < 3 && $urandom % 3 == 0) uart_q.push_back(8'($urandom));
      if ($urandom % 500 == 0) do_reset();
      else step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_stream_bridge.md
UART_STREAM_BRIDGE -- requirements
Module: uart_stream_bridge

Interface
REQ-001 SHALL have parameter POLL_GAP, default 4: idle cycles between status polls; legal range 0..255.
REQ-002 SHALL have parameter RXDEPTH, default 4: RX FIFO entries; power of two, 2..16.
REQ-003 CLK  input  1  clock; single clock domain, all state on rising edge.
REQ-004 RESN  input  1  reset; asynchronous, active-low.
REQ-005 RD  output  1  bus read strobe to UART.
REQ-006 WR  output  1  bus write strobe to UART.
REQ-007 BE  output  4  bus byte enables.
REQ-008 DATAO  output  32  write data to UART; byte lane 1 carries the TX byte.
REQ-009 DATAI  input  32  UART read data: [7:0] status (bit0 xmit busy, bit1 rx ready), [15:8] rx byte, [31:16] baud timer (ignored).
REQ-010 IRQ  input  1  UART interrupt request.
REQ-011 TX_VALID  input  1  upstream byte valid.
REQ-012 TX_DATA  input  8  upstream byte.
REQ-013 TX_READY  output  1  holding register empty.
REQ-014 RX_VALID  output  1  RX FIFO non-empty.
REQ-015 RX_DATA  output  8  RX FIFO head byte (show-ahead).
REQ-016 RX_READY  input  1  downstream pop.

Function
REQ-017 SHALL act as bus initiator to the UART register interface: single-cycle accesses, no wait states; DATAI sampled on the rising edge ending the cycle RD is high.
REQ-018 FSM states SHALL be GAP, POLL, RXRD, TXWR.
REQ-019 GAP: RD=WR=0, BE=0; gap counter loaded with POLL_GAP on entry; decrements each cycle; POLL entered when counter==0 or IRQ==1, so GAP lasts POLL_GAP+1 cycles unless IRQ cuts it short.
REQ-020 POLL: RD=1, BE=4'b0001 (status read, clears UART IRQ); exactly one cycle.
REQ-021 POLL next state, in priority: DATAI[1]==1 and FIFO not full -> RXRD; else DATAI[0]==0 and holding register full -> TXWR; else GAP.
REQ-022 RXRD: RD=1, BE=4'b0010 for one cycle; DATAI[15:8] pushed into RX FIFO on that edge; next state GAP.
REQ-023 TXWR: WR=1, BE=4'b0010, DATAO={16'h0, held byte, 8'h0} for one cycle; holding register cleared on that edge; next state GAP.
REQ-024 DATAO SHALL be 0 in every state other than TXWR.
REQ-025 TX_READY SHALL equal !holding_full; byte captured when TX_VALID && TX_READY; TX_DATA ignored otherwise.
REQ-026 A TX_VALID arriving in the TXWR cycle SHALL NOT be accepted that cycle (TX_READY low); accepted the following cycle.
REQ-027 RX FIFO: RX_VALID=!empty, RX_DATA=head entry; pop on RX_VALID && RX_READY.
REQ-028 Simultaneous push and pop SHALL both take effect; count unchanged; no data lost.
REQ-029 FIFO pointers SHALL wrap modulo RXDEPTH; occupancy counter log2(RXDEPTH)+1 bits.
REQ-030 When FIFO full, RXRD SHALL NOT be issued; the byte stays in the UART (UART-side overrun is outside this block).
REQ-031 Pop with RX_VALID==0 SHALL be ignored; push into full FIFO SHALL be impossible by construction (assertion in bench).
REQ-032 RD and WR SHALL never be high in the same cycle; at most one bus access per cycle.

Reset
REQ-033 RESN low SHALL asynchronously force: state GAP, gap counter=POLL_GAP, RD=0, WR=0, BE=0, DATAO=0, holding register empty (TX_READY=1), FIFO empty (RX_VALID=0, RX_DATA=0).
REQ-034 Reset mid-access or with data buffered SHALL discard buffered bytes; no bus strobe during reset or in the first cycle after release.
REQ-035 After RESN release, first POLL SHALL occur POLL_GAP+1 cycles later (5 at default) absent IRQ.

Verification
REQ-036 Idle: status=0x00, no TX -> RD pulse BE=0001 every 6 cycles, WR never high.
REQ-037 TX: TX_DATA=0x41 accepted, status=0x00 -> next POLL followed by WR, BE=0010, DATAO=0x00004100; TX_READY returns 1 the next cycle.
REQ-038 TX blocked: status=0x01 held 3 polls then 0x00 -> no WR during busy; single WR of held byte after status clears.
REQ-039 RX: status=0x02, DATAI[15:8]=0x5A -> POLL then RD BE=0010; RX_VALID=1, RX_DATA=0x5A next cycle.
REQ-040 RX full: RX_READY=0, 5 bytes 0x01..0x05 offered -> 4 drained, no 5th RXRD; one pop -> 0x05 drained later; order 0x01..0x05 preserved, wrap exercised.
REQ-041 IRQ/reset: IRQ=1 in GAP -> POLL next cycle; RESN low during TXWR -> WR=0 immediately, TX_READY=1, RX_VALID=0.
